// File: rtl/sps_pkg.sv
// Shared definitions for the parking dwell-time block: slot count, the
// 6-bit time type, the mm:ss record, the display FSM encoding and the fee
// helper used when the SPS_FEE_EN build option is enabled.
package sps_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = $clog2(NUM_SLOTS);

  typedef logic [5:0] time_t;

  // Largest value either time field may hold (59 s, 59 min).
  localparam time_t TIME_LIMIT = 6'd59;

  typedef struct packed {
    time_t minutes;
    time_t seconds;
  } dwell_t;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  // Fee for a dwell time: every started minute costs `rate` units, capped at 255.
  function automatic logic [7:0] fee_calc(input dwell_t d, input int unsigned rate);
    int unsigned units;
    int unsigned product;
    units   = 32'(d.minutes) + ((d.seconds != '0) ? 32'd1 : 32'd0);
    product = units * rate;
    return (product > 32'd255) ? 8'd255 : product[7:0];
  endfunction

endpackage

// File: rtl/slot_counter.sv
// Per-slot mm:ss dwell counter: cleared on entry, advanced by the 1 Hz tick
// while the slot is occupied, and held once it reaches 59:59.
module slot_counter
  import sps_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   clear,
  input  logic   tick,
  output dwell_t count
);

  // Clear has priority over tick so an entry coinciding with a tick starts at 00:00.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so every register samples pre-edge values;
    // blocking assignments here would make the result depend on statement order.
    if (reset || clear) begin
      count <= '0;
    end else if (tick) begin
      if (count.seconds != TIME_LIMIT) begin
        count.seconds <= count.seconds + 6'd1;
      end else if (count.minutes != TIME_LIMIT) begin
        count.seconds <= '0;
        count.minutes <= count.minutes + 6'd1;
      end
      // At 59:59 the counter simply holds.
    end
  end

endmodule

// File: rtl/parking_timer.sv
// Parking dwell-time display. Each slot runs its own mm:ss counter; when a
// car leaves, its dwell time is snapshotted and queued, and a two-state FSM
// shows the queued times one at a time (lowest slot first) for SHOW_SECS
// seconds each.
// Build option: define SPS_FEE_EN to compute a per-minute fee on the shown
// slot; without it the fee output is tied to zero.
module parking_timer
  import sps_pkg::*;
#(
  parameter int SHOW_SECS = 5,
  parameter int RATE      = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick_1hz,
  input  logic [NUM_SLOTS-1:0] spots,
  output time_t                minutes,
  output time_t                seconds,
  output logic                 show_active,
  output logic [SLOT_W-1:0]    show_slot,
  output logic [7:0]           fee,
  output logic                 done_pulse
);

  localparam int                CNT_W     = (SHOW_SECS > 1) ? $clog2(SHOW_SECS) : 1;
  localparam logic [CNT_W-1:0]  SHOW_LAST = CNT_W'(SHOW_SECS - 1);

  if (SHOW_SECS < 1 || RATE < 1) begin : g_param_check
    $error("parking_timer: SHOW_SECS and RATE must both be at least 1");
  end

  logic [NUM_SLOTS-1:0] spots_q;
  logic [NUM_SLOTS-1:0] entry;
  logic [NUM_SLOTS-1:0] vacate;
  logic [NUM_SLOTS-1:0] pending;
  dwell_t               count [NUM_SLOTS];
  dwell_t               snap  [NUM_SLOTS];
  state_t               state;
  logic [CNT_W-1:0]     show_cnt;
  logic [SLOT_W-1:0]    sel;
  logic                 load;
  logic [7:0]           fee_next;

  // Registered copy of the occupancy vector used for edge detection.
  always_ff @(posedge clk) begin
    if (reset) spots_q <= '0;
    else       spots_q <= spots;
  end

  assign entry  = spots & ~spots_q;
  assign vacate = ~spots & spots_q;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    slot_counter u_counter (
      .clk   (clk),
      .reset (reset),
      .clear (entry[i]),
      .tick  (tick_1hz & spots[i]),
      .count (count[i])
    );
  end

  // Lowest-index pending slot; scanning downwards lets the lowest hit win.
  always_comb begin
    // NOTE: sel gets a default before the loop so every path assigns it and
    // no latch is inferred when nothing is pending.
    sel = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (pending[i]) sel = SLOT_W'(i);
    end
  end

  // A show starts from IDLE as soon as anything is queued, or back-to-back
  // on the tick that ends the current show.
  assign load = (pending != '0) &&
                ((state == IDLE) || (tick_1hz && (show_cnt == SHOW_LAST)));

`ifdef SPS_FEE_EN
  assign fee_next = fee_calc(snap[sel], int unsigned'(RATE));
`else
  assign fee_next = 8'd0;
`endif

  // Snapshot and queue each vacated slot; a new vacate wins over the
  // service clear and overwrites any unserviced snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      // NOTE: the snapshot array is explicitly reset so a show started right
      // after reset can never expose stale times from before it.
      for (int i = 0; i < NUM_SLOTS; i++) snap[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (vacate[i]) begin
          snap[i]    <= count[i];
          pending[i] <= 1'b1;
        end else if (load && (sel == SLOT_W'(i))) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  // Display FSM with registered outputs: load a snapshot, hold it for
  // SHOW_SECS ticks, then chain to the next one or fall back to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      show_cnt    <= '0;
      minutes     <= '0;
      seconds     <= '0;
      show_slot   <= '0;
      fee         <= '0;
      show_active <= 1'b0;
      done_pulse  <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      if (load) begin
        state       <= SHOW;
        show_cnt    <= '0;
        minutes     <= snap[sel].minutes;
        seconds     <= snap[sel].seconds;
        show_slot   <= sel;
        fee         <= fee_next;
        show_active <= 1'b1;
        done_pulse  <= 1'b1;
      end else if (state == SHOW && tick_1hz) begin
        if (show_cnt == SHOW_LAST) begin
          state       <= IDLE;
          show_cnt    <= '0;
          minutes     <= '0;
          seconds     <= '0;
          show_slot   <= '0;
          fee         <= '0;
          show_active <= 1'b0;
        end else begin
          show_cnt <= show_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_parking_timer.sv
// Directed bench for parking_timer: expected shows are pushed to a
// scoreboard as cars leave and popped whenever done_pulse is seen.
module tb_parking_timer;

  localparam int SHOW_SECS_TB = 5;
  localparam int RATE_TB      = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_1hz;
  logic [3:0] spots;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       show_active;
  logic [1:0] show_slot;
  logic [7:0] fee;
  logic       done_pulse;

  int checks     = 0;
  int failures   = 0;
  int shows_seen = 0;

  typedef struct {
    logic [1:0] slot;
    logic [5:0] mins;
    logic [5:0] secs;
    logic [7:0] fee;
  } exp_t;

  exp_t sb[$];

  parking_timer #(
    .SHOW_SECS (SHOW_SECS_TB),
    .RATE      (RATE_TB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tick_1hz    (tick_1hz),
    .spots       (spots),
    .minutes     (minutes),
    .seconds     (seconds),
    .show_active (show_active),
    .show_slot   (show_slot),
    .fee         (fee),
    .done_pulse  (done_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference dwell for a slot held for `ticks` seconds, saturating at 59:59.
  function automatic exp_t expect_dwell(input int slot, input int ticks);
    exp_t e;
    int   total;
    int   units;
    total  = (ticks > 3599) ? 3599 : ticks;
    e.slot = 2'(slot);
    e.mins = 6'(total / 60);
    e.secs = 6'(total % 60);
`ifdef SPS_FEE_EN
    units = total / 60 + (((total % 60) != 0) ? 1 : 0);
    e.fee = (units * RATE_TB > 255) ? 8'd255 : 8'(units * RATE_TB);
`else
    units = 0;
    e.fee = 8'(units);
`endif
    return e;
  endfunction

  task automatic sample();
    exp_t e;
    if (done_pulse === 1'b1) begin
      shows_seen++;
      if (sb.size() == 0) begin
        check("unexpected_show", 32'(done_pulse), 32'd0);
      end else begin
        e = sb.pop_front();
        check("show_slot",   32'(show_slot),   32'(e.slot));
        check("show_min",    32'(minutes),     32'(e.mins));
        check("show_sec",    32'(seconds),     32'(e.secs));
        check("show_fee",    32'(fee),         32'(e.fee));
        check("show_active", 32'(show_active), 32'd1);
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    sample();
  endtask

  task automatic do_ticks(input int n);
    repeat (n) begin
      tick_1hz = 1'b1;
      cycle();
      tick_1hz = 1'b0;
      cycle();
    end
  endtask

  task automatic wait_show(input string tag, input int lat_exp);
    int start;
    int lat;
    start = shows_seen;
    lat   = 0;
    while (shows_seen == start && lat < 12) begin
      cycle();
      lat++;
    end
    check(tag, 32'(lat), 32'(lat_exp));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_active"}, 32'(show_active), 32'd0);
    check({tag, "_min"},    32'(minutes),     32'd0);
    check({tag, "_sec"},    32'(seconds),     32'd0);
    check({tag, "_slot"},   32'(show_slot),   32'd0);
    check({tag, "_fee"},    32'(fee),         32'd0);
    check({tag, "_done"},   32'(done_pulse),  32'd0);
  endtask

  initial begin
    int s0;

    reset    = 1'b1;
    tick_1hz = 1'b0;
    spots    = 4'b0000;
    cycle();
    cycle();
    check_idle("reset");
    reset = 1'b0;
    cycle();
    check_idle("post_reset");

    // Slot 1 held for 75 s: shows 01:15.
    spots = 4'b0010;
    cycle();
    do_ticks(75);
    sb.push_back(expect_dwell(1, 75));
    spots = 4'b0000;
    wait_show("t1_latency", 2);
    cycle();
    check("t1_done_width", 32'(done_pulse),  32'd0);
    check("t1_active",     32'(show_active), 32'd1);
    do_ticks(SHOW_SECS_TB - 1);
    check("t1_still_active", 32'(show_active), 32'd1);
    do_ticks(1);
    check_idle("t1_end");

    // Slots 0 and 3 leave together after 10 s and 20 s.
    spots = 4'b1000;
    cycle();
    do_ticks(10);
    spots = 4'b1001;
    cycle();
    do_ticks(10);
    sb.push_back(expect_dwell(0, 10));
    sb.push_back(expect_dwell(3, 20));
    spots = 4'b0000;
    wait_show("t2_first", 2);
    s0 = shows_seen;
    do_ticks(SHOW_SECS_TB - 1);
    check("t2_no_early_next", 32'(shows_seen), 32'(s0));
    check("t2_slot_held",     32'(show_slot),  32'd0);
    do_ticks(1);
    check("t2_second_show", 32'(shows_seen), 32'(s0 + 1));
    check("t2_slot3",       32'(show_slot),  32'd3);
    do_ticks(SHOW_SECS_TB);
    check_idle("t2_end");

    // Entry and vacate both coincide with ticks: shows 00:03.
    spots    = 4'b0100;
    tick_1hz = 1'b1;
    cycle();
    tick_1hz = 1'b0;
    cycle();
    do_ticks(3);
    sb.push_back(expect_dwell(2, 3));
    spots    = 4'b0000;
    tick_1hz = 1'b1;
    cycle();
    tick_1hz = 1'b0;
    wait_show("t3_latency", 1);
    do_ticks(SHOW_SECS_TB);
    check_idle("t3_end");

    // Slot 1 leaves, re-enters and leaves again before service: one show
    // with the second dwell time.
    s0    = shows_seen;
    spots = 4'b0011;
    cycle();
    do_ticks(2);
    sb.push_back(expect_dwell(0, 2));
    sb.push_back(expect_dwell(1, 3));
    spots = 4'b0000;
    wait_show("t4_first", 2);
    spots = 4'b0010;
    cycle();
    do_ticks(3);
    spots = 4'b0000;
    cycle();
    do_ticks(2);
    check("t4_overwrite_show", 32'(shows_seen), 32'(s0 + 2));
    do_ticks(SHOW_SECS_TB);
    repeat (6) cycle();
    check("t4_single_pending", 32'(shows_seen), 32'(s0 + 2));
    check_idle("t4_end");

    // Slot 2 held past an hour: saturates at 59:59.
    spots = 4'b0100;
    cycle();
    do_ticks(3605);
    sb.push_back(expect_dwell(2, 3605));
    spots = 4'b0000;
    wait_show("t5_latency", 2);
    do_ticks(SHOW_SECS_TB);
    check_idle("t5_end");

    // Reset in the middle of a show, with slot 3 still queued behind it.
    spots = 4'b1001;
    cycle();
    do_ticks(4);
    sb.push_back(expect_dwell(0, 4));
    spots = 4'b0000;
    wait_show("t6_latency", 2);
    do_ticks(2);
    reset = 1'b1;
    cycle();
    check_idle("t6_reset");
    reset = 1'b0;
    s0    = shows_seen;
    do_ticks(2 * SHOW_SECS_TB);
    check("t6_pending_cleared", 32'(shows_seen), 32'(s0));
    check_idle("t6_after");

    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parking_timer.md
PARKING_TIMER -- requirements
Module: parking_timer

Interface
REQ-001 Parameter: SHOW_SECS, 5, number of tick_1hz pulses a vacated slot's dwell time stays on the outputs.
REQ-002 Parameter: RATE, 2, fee units charged per started minute.
REQ-003 Port: clk  input  1  system clock; the single clock domain.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: tick_1hz  input  1  one-clk-wide enable pulse, once per second.
REQ-006 Port: spots  input  4  occupancy vector from the parking FSM; bit i = slot i occupied.
REQ-007 Port: minutes  output  6  dwell minutes of the slot being shown, 0..59.
REQ-008 Port: seconds  output  6  dwell seconds of the slot being shown, 0..59.
REQ-009 Port: show_active  output  1  high while a dwell time is on the outputs.
REQ-010 Port: show_slot  output  2  index of the slot being shown.
REQ-011 Port: fee  output  8  fee for the shown slot (see Configuration).
REQ-012 Port: done_pulse  output  1  one-clk pulse on the first cycle of each show period.

Function
REQ-013 The block SHALL register spots each cycle and detect, per slot, rising edges (entry) and falling edges (vacate) against the registered copy.
REQ-014 On entry, the slot's counter SHALL clear to 00:00 in that cycle; a coincident tick_1hz SHALL NOT increment it.
REQ-015 While occupied and not entering, each tick_1hz SHALL increment seconds; 59 wraps to 0 with minutes+1.
REQ-016 A counter at 59:59 SHALL saturate, with no further change.
REQ-017 On vacate, the slot's pre-tick counter value SHALL be copied to a per-slot snapshot register and the slot's pending bit SHALL be set.
REQ-018 Re-entry of a pending slot SHALL NOT alter its snapshot; a second vacate before service SHALL overwrite the snapshot and leave one pending entry.
REQ-019 The FSM SHALL have two states, IDLE and SHOW.
REQ-020 IDLE -> SHOW SHALL occur in the cycle after any pending bit is set; the lowest-index pending slot is selected.
REQ-021 On entering SHOW, the block SHALL load minutes/seconds/show_slot from the selected snapshot, clear that pending bit, assert show_active, and pulse done_pulse for one clk.
REQ-022 SHOW SHALL last SHOW_SECS tick_1hz pulses, then return to IDLE, or go directly to the next SHOW if pending bits remain.
REQ-023 In IDLE, minutes, seconds, show_slot and fee SHALL be 0 and show_active SHALL be low.
REQ-024 Simultaneous vacates of several slots SHALL be serviced in ascending index order, one per show period, with none lost.

Reset
REQ-025 On reset, all counters, snapshots, pending bits and the registered spots copy SHALL clear, the FSM SHALL return to IDLE, and every output SHALL be 0.
REQ-026 A reset asserted mid-SHOW SHALL abort the show without a done_pulse; the first cycle after reset SHALL see no edges unless spots differs from 0.

Configuration
REQ-027 Macro SPS_FEE_EN: when defined, fee = (minutes + (seconds != 0)) * RATE, saturated at 255, registered together with minutes.
REQ-028 Without SPS_FEE_EN, fee SHALL be constant 0 and no multiplier SHALL be synthesised.

Structure
REQ-029 The shared package sps_pkg SHALL hold NUM_SLOTS = 4, the 6-bit time typedef, the IDLE/SHOW state encoding and the 59 limit constant.
REQ-030 Per-slot counting SHALL be done in the sub-module slot_counter (clear, tick, saturate), instantiated NUM_SLOTS times.

Verification
REQ-031 Slot 1 occupied, 75 ticks, vacated -> show_slot=1, minutes=1, seconds=15, done_pulse for 1 clk, fee=4 with SPS_FEE_EN.
REQ-032 Slots 0 and 3 vacated in the same cycle after 10 and 20 ticks -> show 00:10 (slot 0) for 5 ticks, then 00:20 (slot 3), then IDLE.
REQ-033 Slot 2 held for 3600+ ticks -> minutes=59, seconds=59 on vacate; fee=120 with RATE=2.
REQ-034 Entry coincident with tick_1hz, then 3 ticks, vacate coincident with a tick -> shows 00:03.
REQ-035 Reset mid-SHOW -> all outputs 0 next cycle, no done_pulse, pending cleared.
REQ-036 Build without SPS_FEE_EN and repeat REQ-031 -> fee=0, timing unchanged.
